// File: rtl/svm_dag_sequencer.sv
// svm_dag_sequencer: walks one shared pairwise SVM engine through a
// one-vs-one DAG decision for one sample and returns the winning class.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   sample handshake; load_en captures the sample
//   eng_start, eng_idx    start pulse and classifier index to the engine
//   eng_done, eng_class   engine result (0: lower class of pair wins)
//   out_valid / out_ready result handshake; out_class is the winner
//   busy, err             not idle; sticky protocol error

module svm_dag_sequencer #(
    parameter int N_CLASSES = 6,
    parameter int IDX_W     = 4,
    parameter int CLS_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             load_en,
    output logic             eng_start,
    output logic [IDX_W-1:0] eng_idx,
    input  logic             eng_done,
    input  logic             eng_class,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CLS_W-1:0] out_class,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        OUT
    } state_t;

    localparam logic [CLS_W-1:0] HI_INIT = CLS_W'(N_CLASSES - 1);
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(N_CLASSES - 1);

    state_t           state_q, state_d;
    logic [CLS_W-1:0] lo_q, lo_d;
    logic [CLS_W-1:0] hi_q, hi_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CLS_W-1:0] out_class_q, out_class_d;
    logic             err_q, err_d;

    assign in_ready  = (state_q == IDLE);
    assign load_en   = in_valid & in_ready;
    assign eng_start = (state_q == START);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign eng_idx   = idx_q;
    assign out_class = out_class_q;
    assign err       = err_q;

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        idx_d       = idx_q;
        out_class_d = out_class_q;
        err_d       = err_q;

        // A result can only be legal while waiting for one.
        if (eng_done && (state_q != WAIT)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    lo_d    = '0;
                    hi_d    = HI_INIT;
                    idx_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    if (eng_class) begin
                        // Skip the remaining pairs of the old lo row.
                        lo_d  = lo_q + CLS_W'(1);
                        idx_d = idx_q + (LAST - IDX_W'(lo_q));
                    end else begin
                        hi_d  = hi_q - CLS_W'(1);
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if (lo_d == hi_d) begin
                        out_class_d = lo_d;
                        state_d     = OUT;
                    end else begin
                        state_d = START;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lo_q        <= '0;
            hi_q        <= HI_INIT;
            idx_q       <= '0;
            out_class_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            idx_q       <= idx_d;
            out_class_q <= out_class_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_svm_dag_sequencer.sv
// tb_svm_dag_sequencer: randomized bench for svm_dag_sequencer with a
// DAG reference model and a behavioural engine of variable latency.

module tb_svm_dag_sequencer;

    localparam int N     = 6;
    localparam int IDX_W = 4;
    localparam int CLS_W = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             load_en;
    logic             eng_start;
    logic [IDX_W-1:0] eng_idx;
    logic             eng_done;
    logic             eng_class;
    logic             out_valid;
    logic             out_ready;
    logic [CLS_W-1:0] out_class;
    logic             busy;
    logic             err;

    int errors = 0;
    int checks = 0;
    int last_idx = 0;

    svm_dag_sequencer #(
        .N_CLASSES(N),
        .IDX_W    (IDX_W),
        .CLS_W    (CLS_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .load_en  (load_en),
        .eng_start(eng_start),
        .eng_idx  (eng_idx),
        .eng_done (eng_done),
        .eng_class(eng_class),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_class(out_class),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Index of pair (lo,hi): rows of the upper triangle, hi descending.
    function automatic int pair_idx(input int lo, input int hi);
        int base;
        base = 0;
        for (int k = 0; k < lo; k++) base += N - 1 - k;
        return base + (N - 1 - hi);
    endfunction

    task automatic hard_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        last_idx = 0;
        step();
    endtask

    task automatic run_sample(input string nm, input bit [N-2:0] bits,
                              input int lat, input int hold,
                              input bit glitch);
        int lo, hi, k, cyc, starts, win, t_out;
        int exp_idx [N-1];
        bit exp_st;
        lo = 0;
        hi = N - 1;
        for (int i = 0; i < N - 1; i++) begin
            exp_idx[i] = pair_idx(lo, hi);
            if (bits[i]) lo++;
            else hi--;
        end
        win = lo;
        t_out = (N - 1) * (lat + 1) + 1;

        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || load_en !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: in_ready=%b load_en=%b want 1 1",
                     nm, in_ready, load_en);
        end
        step();
        in_valid = 1'b0;
        cyc = 1;
        k = 0;
        starts = 0;
        while (out_valid !== 1'b1 && cyc < t_out + 20) begin
            exp_st = (k < N - 1) && (cyc == 1 + k * (lat + 1));
            checks++;
            if (eng_start !== exp_st) begin
                errors++;
                $display("FAIL %s start cyc%0d: got %b want %b",
                         nm, cyc, eng_start, exp_st);
            end
            if (eng_start === 1'b1) begin
                starts++;
                if (k < N - 1) begin
                    checks++;
                    if (eng_idx !== IDX_W'(exp_idx[k])) begin
                        errors++;
                        $display("FAIL %s idx eval%0d: got %0d want %0d",
                                 nm, k, eng_idx, exp_idx[k]);
                    end
                end
            end
            eng_done  = 1'b0;
            eng_class = 1'($urandom);
            if (glitch && cyc == 1) eng_done = 1'b1;
            if (k < N - 1 && cyc == 1 + k * (lat + 1) + lat) begin
                eng_done  = 1'b1;
                eng_class = bits[k];
                k++;
            end
            step();
            cyc++;
        end
        eng_done = 1'b0;

        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: out_valid=%b want 1 by cyc %0d",
                     nm, out_valid, t_out);
            hard_reset();
            in_valid = 1'b0;
            return;
        end
        checks++;
        if (cyc != t_out) begin
            errors++;
            $display("FAIL %s out_cycle: got %0d want %0d", nm, cyc, t_out);
        end
        checks++;
        if (out_class !== CLS_W'(win)) begin
            errors++;
            $display("FAIL %s class: got %0d want %0d", nm, out_class, win);
        end
        checks++;
        if (starts != N - 1) begin
            errors++;
            $display("FAIL %s starts: got %0d want %0d", nm, starts, N - 1);
        end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s out_flags: in_ready=%b busy=%b want 0 1",
                     nm, in_ready, busy);
        end

        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_class !== CLS_W'(win) ||
                in_ready !== 1'b0 || load_en !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: ov=%b cls=%0d ir=%b ld=%b want 1 %0d 0 0",
                         nm, i, out_valid, out_class, in_ready, load_en, win);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        step();
        out_ready = 1'b0;
        if (hold == 0) in_valid = 1'b0;
        last_idx = pair_idx(win, win);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            eng_idx !== IDX_W'(last_idx)) begin
            errors++;
            $display("FAIL %s after_hs: ov=%b ir=%b idx=%0d want 0 1 %0d",
                     nm, out_valid, in_ready, eng_idx, last_idx);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({in_ready, load_en, eng_start, eng_idx, out_valid, out_class,
             busy, err} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0})
        begin
            errors++;
            $display("FAIL reset: ir=%b ld=%b st=%b idx=%0d ov=%b cls=%0d busy=%b err=%b want 1 0 0 0 0 0 0 0",
                     in_ready, load_en, eng_start, eng_idx, out_valid,
                     out_class, busy, err);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_all_lower();
        run_sample("all_lower", 5'b00000, 1, 0, 1'b0);
    endtask

    task automatic test_all_higher();
        run_sample("all_higher", 5'b11111, 1, 0, 1'b0);
    endtask

    task automatic test_alternating();
        run_sample("alternating", 5'b10101, 1, 0, 1'b0);
    endtask

    task automatic test_hold();
        run_sample("hold", 5'($urandom), 1, 10, 1'b0);
        run_sample("after_hold", 5'($urandom), 2, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            run_sample($sformatf("b2b%0d", i), 5'($urandom),
                       int'($urandom_range(1, 4)), 0, 1'b0);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_err: got %b want 0", err);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 1; c < 6; c++) begin
            eng_done  = (c == 2 || c == 4);
            eng_class = 1'($urandom);
            step();
        end
        eng_done = 1'b0;
        checks++;
        if (busy !== 1'b1 || eng_start !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait: busy=%b start=%b want 1 0",
                     busy, eng_start);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, load_en, eng_start, eng_idx, out_valid, out_class,
             busy, err} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0})
        begin
            errors++;
            $display("FAIL reset_mid: ir=%b ld=%b st=%b idx=%0d ov=%b cls=%0d busy=%b err=%b want 1 0 0 0 0 0 0 0",
                     in_ready, load_en, eng_start, eng_idx, out_valid,
                     out_class, busy, err);
        end
        last_idx = 0;
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ir=%b ov=%b want 1 0",
                     in_ready, out_valid);
        end
        run_sample("after_reset", 5'($urandom), 1, 0, 1'b0);
    endtask

    task automatic test_errors();
        eng_done  = 1'b1;
        eng_class = 1'($urandom);
        step();
        eng_done = 1'b0;
        checks++;
        if (err !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 ||
            eng_idx !== IDX_W'(last_idx)) begin
            errors++;
            $display("FAIL err_idle: err=%b ir=%b busy=%b idx=%0d want 1 1 0 %0d",
                     err, in_ready, busy, eng_idx, last_idx);
        end
        step();
        step();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
        run_sample("err_start", 5'($urandom), 2, 0, 1'b1);
        run_sample("err_legal", 5'($urandom), 1, 0, 1'b0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_end: got %b want 1", err);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        eng_done  = 1'b0;
        eng_class = 1'b0;
        test_reset();
        test_all_lower();
        test_all_higher();
        test_alternating();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_errors();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
